// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter and beat sequencer for one shared memory port.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN; fixed dcache priority otherwise.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_req_data_valid,
    output logic                dc_req_data_ready,
    input  logic [DATA_W-1:0]   dc_req_data,
    input  logic [DATA_W/8-1:0] dc_req_data_mask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner_dc;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic              w_prefer_dc;
    logic              w_grant_dc;
    logic              w_grant_ic;
    logic              w_beat;
    logic              w_last_beat;

`ifdef MEM_ARB_RR_EN
    logic r_prefer_dc;

    // Pointer favours whichever requester did not win the most recent grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prefer_dc <= 1'b1;
        end else if (w_grant_dc || w_grant_ic) begin
            r_prefer_dc <= w_grant_ic;
        end
    end
    assign w_prefer_dc = r_prefer_dc;
`else
    assign w_prefer_dc = 1'b1;
`endif

    assign w_grant_dc  = (r_state == IDLE) && dc_req_valid && (!ic_req_valid || w_prefer_dc);
    assign w_grant_ic  = (r_state == IDLE) && ic_req_valid && !w_grant_dc;
    assign w_beat      = ((r_state == WDATA) && dc_req_data_valid && mem_req_data_ready) ||
                         ((r_state == RESP) && mem_resp_valid);
    assign w_last_beat = w_beat && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner_dc <= 1'b1;
            r_rw       <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_dc || w_grant_ic) begin
                r_owner_dc <= w_grant_dc;
                r_rw       <= w_grant_dc && dc_req_rw;
                r_addr     <= w_grant_dc ? dc_req_addr : ic_req_addr;
                r_cnt      <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        ic_req_ready       = w_grant_ic;
        dc_req_ready       = w_grant_dc;
        mem_req_valid      = 1'b0;
        mem_req_rw         = r_rw;
        mem_req_addr       = r_addr;
        mem_req_data_valid = 1'b0;
        dc_req_data_ready  = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        ic_resp_data       = '0;
        dc_resp_data       = '0;
        busy               = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_grant_dc || w_grant_ic) w_next = ISSUE;
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_next = r_rw ? WDATA : RESP;
            end
            WDATA: begin
                mem_req_data_valid = dc_req_data_valid;
                dc_req_data_ready  = mem_req_data_ready;
                mem_req_data_bits  = dc_req_data;
                mem_req_data_mask  = dc_req_data_mask;
                if (w_last_beat) w_next = IDLE;
            end
            RESP: begin
                // Response beats route to the owner only; data is broadcast.
                ic_resp_valid = mem_resp_valid && !r_owner_dc;
                dc_resp_valid = mem_resp_valid && r_owner_dc;
                ic_resp_data  = mem_resp_data;
                dc_resp_data  = mem_resp_data;
                if (w_last_beat) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
